// File: rtl/gcd_sub_ctrl_pkg.sv
// Shared types and defaults for the subtract-based GCD sequencer.
package gcd_sub_ctrl_pkg;

    localparam int unsigned GCD_WIDTH_DEFAULT     = 32;
    localparam int unsigned GCD_MAX_STEPS_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIN   = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_sub_ctrl_if.sv
// Request/response bundle between a requesting controller and the GCD sequencer.
interface gcd_sub_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 11
);
    logic             go;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] steps;
    logic             timeout;

    modport master (
        output go, a_in, b_in,
        input  busy, done, result, steps, timeout
    );

    modport slave (
        input  go, a_in, b_in,
        output busy, done, result, steps, timeout
    );
endinterface

// File: rtl/std_sub.sv
// Plain unsigned subtractor; callers guarantee left >= right.
module std_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out
);
    assign out = left - right;
endmodule

// File: rtl/gcd_sub_ctrl.sv
// GCD by repeated subtraction: schedules one shared subtractor over multiple
// cycles with a go/done handshake and a per-job step limit.
module gcd_sub_ctrl
    import gcd_sub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = GCD_WIDTH_DEFAULT,
    parameter int unsigned MAX_STEPS = GCD_MAX_STEPS_DEFAULT,
    parameter int unsigned CNT_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    gcd_sub_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    gcd_state_t       state_q,   state_d;
    logic [WIDTH-1:0] ra_q,      ra_d;
    logic [WIDTH-1:0] rb_q,      rb_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [CNT_W-1:0] steps_q,   steps_d;
    logic             timeout_q, timeout_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             ra_gt_rb_c;
    logic [WIDTH-1:0] sub_l_c;
    logic [WIDTH-1:0] sub_r_c;
    logic [WIDTH-1:0] diff_c;

    // Larger operand always on the left so the difference cannot underflow.
    assign ra_gt_rb_c = (ra_q > rb_q);
    assign sub_l_c    = ra_gt_rb_c ? ra_q : rb_q;
    assign sub_r_c    = ra_gt_rb_c ? rb_q : ra_q;

    std_sub #(.WIDTH(WIDTH)) u_sub (
        .left  (sub_l_c),
        .right (sub_r_c),
        .out   (diff_c)
    );

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        steps_d   = steps_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    ra_d      = bus.a_in;
                    rb_d      = bus.b_in;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                // One action per cycle; termination tests outrank the step limit.
                if ((ra_q == '0) || (rb_q == '0)) begin
                    result_d = ra_q | rb_q;
                    steps_d  = cnt_q;
                    state_d  = FIN;
                end else if (ra_q == rb_q) begin
                    result_d = ra_q;
                    steps_d  = cnt_q;
                    state_d  = FIN;
                end else if (cnt_q == MAX_CNT) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    steps_d   = cnt_q;
                    state_d   = FIN;
                end else begin
                    if (ra_gt_rb_c) begin
                        ra_d = diff_c;
                    end else begin
                        rb_d = diff_c;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            steps_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            steps_q   <= steps_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.steps   = steps_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_gcd_sub_ctrl.sv
// Directed, table-driven bench for gcd_sub_ctrl with a small step limit.
module tb_gcd_sub_ctrl;
    localparam int unsigned W  = 32;
    localparam int unsigned MS = 16;
    localparam int unsigned CW = $clog2(MS + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gcd_sub_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    gcd_sub_ctrl #(.WIDTH(W), .MAX_STEPS(MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int unsigned  steps;
        logic         to;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one job and watch it to completion; returns in the first idle cycle.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_go,
                           output logic [W-1:0] res, output logic [CW-1:0] st, output logic to,
                           output int lat, output int busyc, output bit got);
        @(negedge clk);
        bus.go   = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        @(posedge clk);
        #1;
        if (!hold_go) bus.go = 1'b0;
        lat = 0; busyc = 0; got = 1'b0;
        res = '0; st = '0; to = 1'b0;
        while (!got && lat < 100) begin
            if (bus.busy) busyc++;
            if (bus.done) begin
                got = 1'b1;
                res = bus.result;
                st  = bus.steps;
                to  = bus.timeout;
            end else begin
                if (hold_go) begin
                    bus.a_in = W'($urandom);
                    bus.b_in = W'($urandom);
                end
                @(posedge clk);
                #1;
                lat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] er, input int unsigned es, input logic et,
                                 input bit hold_go);
        logic [W-1:0]  res;
        logic [CW-1:0] st;
        logic          to;
        int            lat, busyc;
        bit            got;
        run_job(a, b, hold_go, res, st, to, lat, busyc, got);
        check({tag, " done_seen"}, 64'(got), 64'(1));
        check({tag, " result"},    64'(res), 64'(er));
        check({tag, " steps"},     64'(st),  64'(es));
        check({tag, " timeout"},   64'(to),  64'(et));
        check({tag, " latency"},   64'(lat), 64'(es + 1));
        check({tag, " busy_cycles"}, 64'(busyc), 64'(es + 2));
        check({tag, " idle_busy"}, 64'(bus.busy), 64'(0));
        check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
        // With go still high in the idle cycle, the next edge must start a new job.
        if (hold_go) begin
            @(posedge clk);
            #1;
            check({tag, " restart_in_idle"}, 64'(bus.busy), 64'(1));
            bus.go = 1'b0;
            repeat (MS + 4) @(posedge clk);
            #1;
            check({tag, " restart_drained"}, 64'(bus.busy), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;

        vecs[0]  = '{a: 32'd48,         b: 32'd18,         res: 32'd6,          steps: 4,  to: 1'b0};
        vecs[1]  = '{a: 32'd0,          b: 32'd5,          res: 32'd5,          steps: 0,  to: 1'b0};
        vecs[2]  = '{a: 32'd0,          b: 32'd0,          res: 32'd0,          steps: 0,  to: 1'b0};
        vecs[3]  = '{a: 32'd5,          b: 32'd0,          res: 32'd5,          steps: 0,  to: 1'b0};
        vecs[4]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'hFFFF_FFFF,  steps: 0,  to: 1'b0};
        vecs[5]  = '{a: 32'd7,          b: 32'd3,          res: 32'd1,          steps: 4,  to: 1'b0};
        vecs[6]  = '{a: 32'd21,         b: 32'd6,          res: 32'd3,          steps: 4,  to: 1'b0};
        vecs[7]  = '{a: 32'd2,          b: 32'd3,          res: 32'd1,          steps: 2,  to: 1'b0};
        vecs[8]  = '{a: 32'd17,         b: 32'd1,          res: 32'd1,          steps: 16, to: 1'b0};
        vecs[9]  = '{a: 32'd18,         b: 32'd1,          res: 32'd0,          steps: 16, to: 1'b1};
        vecs[10] = '{a: 32'd1000,       b: 32'd1,          res: 32'd0,          steps: 16, to: 1'b1};
        vecs[11] = '{a: 32'd1,          b: 32'hFFFF_FFFF,  res: 32'd0,          steps: 16, to: 1'b1};

        reset    = 1'b0;
        bus.go   = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        #12;
        check("reset busy",    64'(bus.busy),    64'(0));
        check("reset done",    64'(bus.done),    64'(0));
        check("reset result",  64'(bus.result),  64'(0));
        check("reset steps",   64'(bus.steps),   64'(0));
        check("reset timeout", 64'(bus.timeout), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Consecutive entries start in the first idle cycle after the previous done.
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                          vecs[i].res, vecs[i].steps, vecs[i].to, 1'b0);
        end

        // go held high with changing operands throughout the job.
        run_and_check("hold_go", 32'd48, 32'd18, 32'd6, 4, 1'b0, 1'b1);

        // Asynchronous reset in the middle of CHECK.
        @(negedge clk);
        bus.go   = 1'b1;
        bus.a_in = 32'd48;
        bus.b_in = 32'd18;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("midjob busy_before", 64'(bus.busy), 64'(1));
        reset = 1'b0;
        #1;
        check("midjob busy",    64'(bus.busy),    64'(0));
        check("midjob done",    64'(bus.done),    64'(0));
        check("midjob result",  64'(bus.result),  64'(0));
        check("midjob steps",   64'(bus.steps),   64'(0));
        check("midjob timeout", 64'(bus.timeout), 64'(0));
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("midjob no_done", 64'(saw_done), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        run_and_check("after_reset", 32'd48, 32'd18, 32'd6, 4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
